fc_dense: RTL and testbench
===========================

// Module: fc_dense
// PURPOSE
//  Fully-connected layer directly downstream of the average-pooling stage. Captures one pooled
//  vector (VEC_LEN words) from the pooling output stream, then computes NOUT neuron outputs
//  y[o] = sum_i x[i]*w[o][i] + b[o] with weights/biases read from an external 1-port weight RAM.
//  Results are rounded, saturated and streamed out with a valid/ready handshake and overflow flag.
// PARAMETERS
//  INWIDTH   16   data width of DIN/DOUT, signed fixed point
//  IN_FRAC   12   fractional bits of DIN, DOUT and bias words
//  W_WIDTH   16   weight word width, signed
//  W_FRAC    12   fractional bits of weights
//  VEC_LEN   325  input vector length (25x13 pooled map)
//  NOUT      12   number of output neurons
//  ACC_WIDTH 40   signed accumulator width
// PORTS
//  CLK       in   1                 clock
//  RESET     in   1                 asynchronous, active-high reset
//  EN        in   1                 global clock enable; all state holds while low
//  START     in   1                 begin one frame; honoured only in IDLE
//  DIN       in   INWIDTH           pooled input word
//  DIN_VLD   in   1                 DIN valid
//  DIN_RDY   out  1                 high in LOAD state only
//  DIN_OVFL  in   1                 overflow flag accompanying DIN
//  W_ADDR    out  $clog2(NOUT*(VEC_LEN+1))  weight RAM address, row o at o*(VEC_LEN+1)
//  W_RD      out  1                 weight RAM read strobe
//  W_DATA    in   W_WIDTH           weight RAM data, valid 1 EN-cycle after W_RD
//  DOUT      out  INWIDTH           neuron result
//  DOUT_VLD  out  1                 DOUT valid
//  DOUT_RDY  in   1                 downstream ready
//  DOUT_OVFL out  1                 result saturated, or any DIN_OVFL seen in this frame
//  BUSY      out  1                 high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE; DIN_RDY, W_RD, DOUT_VLD, DOUT_OVFL, BUSY = 0; DOUT, W_ADDR = 0; sticky flag cleared.
//  - FSM: IDLE -START-> LOAD -VEC_LEN transfers-> MAC -last acc-> RND -> OUTP -DOUT_VLD&DOUT_RDY->
//    MAC (next neuron) or IDLE (after neuron NOUT-1). START outside IDLE ignored.
//  - LOAD: transfer = DIN_VLD & DIN_RDY; word stored in internal vector RAM at index 0..VEC_LEN-1;
//    DIN_OVFL ORed into sticky frame flag. DIN_VLD outside LOAD ignored.
//  - MAC: issue index k=0..VEC_LEN, one per cycle, W_RD=1, W_ADDR=o*(VEC_LEN+1)+k; vector RAM read
//    in the same cycle. k<VEC_LEN: product x[k]*w (INWIDTH+W_WIDTH bits, IN_FRAC+W_FRAC frac)
//    registered, then added to accumulator. k=VEC_LEN: W_DATA is bias b[o] (IN_FRAC frac),
//    sign-extended and shifted left W_FRAC before adding. Accumulator cleared at MAC entry.
//  - Latency: DOUT_VLD rises exactly VEC_LEN+5 EN-cycles after MAC entry for each neuron.
//  - RND: add 2^(W_FRAC-1), arithmetic shift right W_FRAC (round half up), saturate to INWIDTH signed
//    range [0x8000,0x7FFF] for defaults; DOUT_OVFL = saturated | sticky flag.
//  - OUTP: DOUT/DOUT_VLD/DOUT_OVFL held stable until DOUT_RDY; no W_RD issued while waiting.
//  - Accumulator wrap is not detected; ACC_WIDTH must cover VEC_LEN products.
//  - EN low: all registers, counters and pipeline hold; weight RAM shares EN so W_DATA is preserved.
//  - RESET mid-frame: immediate return to IDLE, pending output discarded, vector contents don't-care.
// CONFIGURATION
//  FC_RELU_EN defined: negative rounded results output as 0; DOUT_OVFL from saturation only on
//  positive overflow. Undefined: full signed output, symmetric saturation.
// TESTING (VEC_LEN=4, NOUT=2 unless noted)
//  1. x=0x1000 x4, w=0x0800 x4, bias 0 -> DOUT 0x2000 both neurons, OVFL=0, VLD at MAC entry+9.
//  2. x=0x7000 x4, w=0x7000 x4 -> DOUT 0x7FFF, DOUT_OVFL=1; with DIN_OVFL on x[2] all outputs OVFL=1.
//  3. x=0x1000 x4, w=0xFC00 x4, bias 0 -> DOUT 0xF000 (0x0000 with FC_RELU_EN), OVFL=0.
//  4. x=0x0001,0,0,0, w0=0x0800, bias 0 -> DOUT 0x0001 (half LSB rounds up); bias 0x0100 -> 0x0101.
//  5. DOUT_RDY low 10 cycles on neuron 0 -> DOUT stable, W_RD=0 throughout; neuron 1 MAC starts next cycle.
//  6. RESET asserted mid-MAC -> all outputs 0 asynchronously; new START+frame gives results of test 1.

Source files
------------

// File: rtl/fc_dense_if.sv
// fc_dense_if: stream, weight-RAM and control signals of the fc_dense layer.
// The slave modport is the fc_dense side; the master modport is its environment
// (pooling stage, weight RAM and downstream consumer).
interface fc_dense_if #(
    parameter int INWIDTH = 16,
    parameter int W_WIDTH = 16,
    parameter int AW      = 12
);
    logic               EN;
    logic               START;
    logic [INWIDTH-1:0] DIN;
    logic               DIN_VLD;
    logic               DIN_RDY;
    logic               DIN_OVFL;
    logic [AW-1:0]      W_ADDR;
    logic               W_RD;
    logic [W_WIDTH-1:0] W_DATA;
    logic [INWIDTH-1:0] DOUT;
    logic               DOUT_VLD;
    logic               DOUT_RDY;
    logic               DOUT_OVFL;
    logic               BUSY;

    modport master (
        output EN, START, DIN, DIN_VLD, DIN_OVFL, W_DATA, DOUT_RDY,
        input  DIN_RDY, W_ADDR, W_RD, DOUT, DOUT_VLD, DOUT_OVFL, BUSY
    );

    modport slave (
        input  EN, START, DIN, DIN_VLD, DIN_OVFL, W_DATA, DOUT_RDY,
        output DIN_RDY, W_ADDR, W_RD, DOUT, DOUT_VLD, DOUT_OVFL, BUSY
    );
endinterface

// File: rtl/fc_dense.sv
// fc_dense: fully-connected layer after the average-pooling stage.
// Captures one VEC_LEN-word vector, then for each of NOUT neurons streams
// weights and bias from an external 1-port RAM (row o at o*(VEC_LEN+1)),
// accumulates, rounds half up, saturates and hands the result downstream.
// Pipeline per issued index: issue -> operand regs -> product reg -> accumulator.
// Optional feature macro FC_RELU_EN: clamp negative results to zero.
module fc_dense #(
    parameter int INWIDTH   = 16,
    parameter int IN_FRAC   = 12,
    parameter int W_WIDTH   = 16,
    parameter int W_FRAC    = 12,
    parameter int VEC_LEN   = 325,
    parameter int NOUT      = 12,
    parameter int ACC_WIDTH = 40
) (
    input logic       CLK,
    input logic       RESET,
    fc_dense_if.slave bus
);
    localparam int AW  = $clog2(NOUT * (VEC_LEN + 1));
    localparam int VIW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int KW  = $clog2(VEC_LEN + 2);
    localparam int OW  = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int PW  = INWIDTH + W_WIDTH;
    // product fraction minus output fraction: bias alignment and rounding shift
    localparam int RSH = (IN_FRAC + W_FRAC) - IN_FRAC;

    localparam logic [VIW-1:0] LD_LAST  = VIW'(VEC_LEN - 1);
    localparam logic [KW-1:0]  K_BIAS   = KW'(VEC_LEN);
    localparam logic [OW-1:0]  O_LAST   = OW'(NOUT - 1);
    localparam logic [AW-1:0]  ROW_STEP = AW'(VEC_LEN + 1);
    localparam logic signed [ACC_WIDTH-1:0] HALF    = ACC_WIDTH'(1) <<< (RSH - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (ACC_WIDTH'(1) <<< (INWIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -(ACC_WIDTH'(1) <<< (INWIDTH - 1));

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_RND, S_OUTP} state_t;

    state_t state, state_nx;
    logic   din_rdy, busy, issuing, mac_entry;

    logic signed [INWIDTH-1:0]   vec_mem [VEC_LEN];
    logic [VIW-1:0]              ld_cnt;
    logic [KW-1:0]               k;
    logic [OW-1:0]               o_cnt;
    logic [AW-1:0]               row_base;
    logic                        sticky;

    logic signed [INWIDTH-1:0]   x_q;
    logic signed [W_WIDTH-1:0]   w_s;
    logic signed [PW-1:0]        mul;
    logic signed [ACC_WIDTH-1:0] bias_al, prod_q, acc, rsum, rsh;
    logic                        s1_vld, s1_bias, s2_vld, s2_last, done_q;
    logic [INWIDTH-1:0]          res, dout_q;
    logic                        sat, dout_vld_q, dout_ovfl_q;

    assign w_s     = bus.W_DATA;
    assign mul     = x_q * w_s;
    assign bias_al = ACC_WIDTH'(w_s) <<< RSH;

    // state register, frozen while EN is low
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)       state <= S_IDLE;
        else if (bus.EN) state <= state_nx;
    end

    // next-state logic and state-decoded strobes
    always_comb begin
        state_nx = state;
        din_rdy  = 1'b0;
        issuing  = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: if (bus.START) state_nx = S_LOAD;
            S_LOAD: begin
                din_rdy = 1'b1;
                if (bus.DIN_VLD && ld_cnt == LD_LAST) state_nx = S_MAC;
            end
            S_MAC: begin
                issuing = (k <= K_BIAS);
                if (done_q) state_nx = S_RND;
            end
            S_RND:  state_nx = S_OUTP;
            S_OUTP: if (bus.DOUT_RDY) state_nx = (o_cnt == O_LAST) ? S_IDLE : S_MAC;
            default: state_nx = S_IDLE;
        endcase
        mac_entry = (state_nx == S_MAC) && (state != S_MAC);
    end

    // vector RAM: written during LOAD, read alongside each weight fetch
    always_ff @(posedge CLK) begin
        if (bus.EN) begin
            if (din_rdy && bus.DIN_VLD) vec_mem[ld_cnt] <= bus.DIN;
            if (issuing && k != K_BIAS) x_q <= vec_mem[VIW'(k)];
        end
    end

    // frame bookkeeping: load index, issue index, neuron index, row base, sticky overflow
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ld_cnt   <= '0;
            k        <= '0;
            o_cnt    <= '0;
            row_base <= '0;
            sticky   <= 1'b0;
        end else if (bus.EN) begin
            if (state == S_IDLE && bus.START) begin
                ld_cnt   <= '0;
                o_cnt    <= '0;
                row_base <= '0;
                sticky   <= 1'b0;
            end
            if (din_rdy && bus.DIN_VLD) begin
                ld_cnt <= ld_cnt + 1'b1;
                sticky <= sticky | bus.DIN_OVFL;
            end
            if (mac_entry)    k <= '0;
            else if (issuing) k <= k + 1'b1;
            if (state == S_OUTP && bus.DOUT_RDY) begin
                o_cnt    <= o_cnt + 1'b1;
                row_base <= row_base + ROW_STEP;
            end
        end
    end

    // MAC pipeline: tags follow each issued index; done_q marks the bias add landing
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_vld  <= 1'b0;
            s1_bias <= 1'b0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            prod_q  <= '0;
            acc     <= '0;
            done_q  <= 1'b0;
        end else if (bus.EN) begin
            s1_vld  <= issuing;
            s1_bias <= issuing && (k == K_BIAS);
            s2_vld  <= s1_vld;
            s2_last <= s1_bias;
            if (s1_vld) prod_q <= s1_bias ? bias_al : ACC_WIDTH'(mul);
            if (mac_entry)   acc <= '0;
            else if (s2_vld) acc <= acc + prod_q;
            done_q <= s2_vld && s2_last;
        end
    end

    // round half up, then saturate (or clamp negatives with FC_RELU_EN)
    always_comb begin
        rsum = acc + HALF;
        rsh  = rsum >>> RSH;
        sat  = 1'b0;
        res  = INWIDTH'(rsh);
`ifdef FC_RELU_EN
        if (rsh[ACC_WIDTH-1]) begin
            res = '0;
        end else if (rsh > SAT_MAX) begin
            res = INWIDTH'(SAT_MAX);
            sat = 1'b1;
        end
`else
        if (rsh > SAT_MAX) begin
            res = INWIDTH'(SAT_MAX);
            sat = 1'b1;
        end else if (rsh < SAT_MIN) begin
            res = INWIDTH'(SAT_MIN);
            sat = 1'b1;
        end
`endif
    end

    // output register: loaded in RND, held until the downstream handshake
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            dout_ovfl_q <= 1'b0;
        end else if (bus.EN) begin
            if (state == S_RND) begin
                dout_q      <= res;
                dout_vld_q  <= 1'b1;
                dout_ovfl_q <= sat | sticky;
            end else if (state == S_OUTP && bus.DOUT_RDY) begin
                dout_vld_q  <= 1'b0;
                dout_ovfl_q <= 1'b0;
            end
        end
    end

    assign bus.DIN_RDY   = din_rdy;
    assign bus.BUSY      = busy;
    assign bus.W_RD      = issuing;
    assign bus.W_ADDR    = issuing ? row_base + AW'(k) : '0;
    assign bus.DOUT      = dout_q;
    assign bus.DOUT_VLD  = dout_vld_q;
    assign bus.DOUT_OVFL = dout_ovfl_q;
endmodule

// File: tb/tb_fc_dense.sv
// tb_fc_dense: directed frames with hand-computed results pushed to a scoreboard;
// an independent monitor pops and compares every accepted output, checks
// MAC-entry-to-valid latency, output hold under back-pressure, and the next
// neuron's immediate restart.
module tb_fc_dense;
    localparam int VL = 4;
    localparam int NO = 2;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;

    fc_dense_if #(.INWIDTH(16), .W_WIDTH(16), .AW(AW)) bus ();

    fc_dense #(.VEC_LEN(VL), .NOUT(NO)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // external weight RAM, one EN-cycle read latency
    logic [15:0] wram [NO*(VL+1)];
    always @(posedge clk) if (bus.EN && bus.W_RD) bus.W_DATA <= wram[bus.W_ADDR];

    int checks   = 0;
    int failures = 0;
    logic [16:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_row(input int o, input logic [63:0] ws, input logic [15:0] b);
        for (int i = 0; i < VL; i++) wram[o*(VL+1)+i] = ws[16*i +: 16];
        wram[o*(VL+1)+VL] = b;
    endtask

    task automatic expect_out(input logic [15:0] d, input logic o);
        exp_q.push_back({o, d});
    endtask

    task automatic frame(input logic [63:0] xs, input logic [3:0] om);
        int t;
        @(negedge clk); bus.START = 1'b1;
        @(negedge clk); bus.START = 1'b0;
        for (int i = 0; i < VL; i++) begin
            if (i == 2) begin bus.DIN_VLD = 1'b0; @(negedge clk); end
            bus.DIN = xs[16*i +: 16]; bus.DIN_OVFL = om[i]; bus.DIN_VLD = 1'b1;
            t = 0;
            while (!bus.DIN_RDY && t < 20) begin @(negedge clk); t++; end
            if (!bus.DIN_RDY) chk("din_rdy_timeout", 32'd0, 32'd1);
            @(negedge clk);
        end
        bus.DIN_VLD = 1'b0; bus.DIN_OVFL = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.BUSY && t < 500) begin @(negedge clk); t++; end
        if (bus.BUSY) chk("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_sig(input bit which_vld);
        int t = 0;
        while (!(which_vld ? bus.DOUT_VLD : bus.W_RD) && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk(which_vld ? "vld_timeout" : "wrd_timeout", 32'd0, 32'd1);
    endtask

    // monitor: samples 1 time unit after the falling edge, after stimulus settles
    int   lat_cnt = 0;
    bit   lat_on = 0, hs_prev = 0, en_prev = 1;
    logic wrd_prev = 1'b0;
    always @(negedge clk) begin
        logic [16:0] e;
        #1;
        if (rst) begin
            lat_on = 0; hs_prev = 0; wrd_prev = 1'b0; en_prev = bus.EN;
        end else begin
            if (lat_on && en_prev) lat_cnt++;
            if (bus.W_RD && !wrd_prev) begin lat_cnt = 0; lat_on = 1; end
            if (hs_prev && bus.BUSY) chk("next_mac_wrd", {31'd0, bus.W_RD}, 32'd1);
            hs_prev = 0;
            if (bus.DOUT_VLD && lat_on) begin
                chk("latency", lat_cnt, VL + 5);
                lat_on = 0;
            end
            if (bus.DOUT_VLD && !bus.DOUT_RDY && exp_q.size() > 0) begin
                chk("hold_data", {15'd0, bus.DOUT_OVFL, bus.DOUT}, {15'd0, exp_q[0]});
                chk("hold_no_wrd", {31'd0, bus.W_RD}, 32'd0);
            end
            if (bus.DOUT_VLD && bus.DOUT_RDY && bus.EN) begin
                chk("queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("dout", {16'd0, bus.DOUT}, {16'd0, e[15:0]});
                    chk("dout_ovfl", {31'd0, bus.DOUT_OVFL}, {31'd0, e[16]});
                end
                hs_prev = 1;
            end
            wrd_prev = bus.W_RD;
            en_prev  = bus.EN;
        end
    end

    initial begin
        rst = 1'b1;
        bus.EN = 1'b1; bus.START = 1'b0; bus.DIN = '0; bus.DIN_VLD = 1'b0;
        bus.DIN_OVFL = 1'b0; bus.DOUT_RDY = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {7'd0, bus.DIN_RDY, bus.W_RD, bus.DOUT_VLD, bus.DOUT_OVFL,
                              bus.BUSY, bus.DOUT, bus.W_ADDR}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: 4 x (1.0 * 0.5) = 2.0; DIN_VLD while IDLE must be ignored
        set_row(0, {4{16'h0800}}, 16'h0000);
        set_row(1, {4{16'h0800}}, 16'h0000);
        bus.DIN = 16'h7FFF; bus.DIN_VLD = 1'b1;
        repeat (3) @(negedge clk);
        expect_out(16'h2000, 1'b0); expect_out(16'h2000, 1'b0);
        frame({4{16'h1000}}, 4'b0000);
        wait_idle();

        // 1b: same data, DIN_OVFL on x[2] flags every output of the frame
        expect_out(16'h2000, 1'b1); expect_out(16'h2000, 1'b1);
        frame({4{16'h1000}}, 4'b0100);
        wait_idle();

        // 2: 4 x 49 = 196 -> positive saturation; with -7 weights -> negative saturation
        set_row(0, {4{16'h7000}}, 16'h0000);
        set_row(1, {4{16'h9000}}, 16'h0000);
        expect_out(16'h7FFF, 1'b1);
`ifdef FC_RELU_EN
        expect_out(16'h0000, 1'b0);
`else
        expect_out(16'h8000, 1'b1);
`endif
        frame({4{16'h7000}}, 4'b0000);
        wait_idle();

        // 3: 4 x (1.0 * -0.25) = -1.0; START pulsed mid-MAC must be ignored
        set_row(0, {4{16'hFC00}}, 16'h0000);
        set_row(1, {4{16'hFC00}}, 16'h0000);
`ifdef FC_RELU_EN
        expect_out(16'h0000, 1'b0); expect_out(16'h0000, 1'b0);
`else
        expect_out(16'hF000, 1'b0); expect_out(16'hF000, 1'b0);
`endif
        frame({4{16'h1000}}, 4'b0000);
        bus.START = 1'b1; @(negedge clk); bus.START = 1'b0;
        wait_idle();

        // 4: half LSB rounds up; bias 0x0100 adds 1/16; EN dropped for 3 cycles mid-MAC
        set_row(0, {16'h0, 16'h0, 16'h0, 16'h0800}, 16'h0000);
        set_row(1, {16'h0, 16'h0, 16'h0, 16'h0800}, 16'h0100);
        expect_out(16'h0001, 1'b0); expect_out(16'h0101, 1'b0);
        frame({16'h0, 16'h0, 16'h0, 16'h0001}, 4'b0000);
        @(negedge clk); bus.EN = 1'b0;
        repeat (3) @(negedge clk); bus.EN = 1'b1;
        wait_idle();

        // 4b: -0.5 LSB rounds up to 0; -0.5002 LSB rounds to -1
        set_row(0, {16'h0, 16'h0, 16'h0, 16'h0800}, 16'h0000);
        set_row(1, {16'h0, 16'h0, 16'h0, 16'h0801}, 16'h0000);
        expect_out(16'h0000, 1'b0);
`ifdef FC_RELU_EN
        expect_out(16'h0000, 1'b0);
`else
        expect_out(16'hFFFF, 1'b0);
`endif
        frame({16'h0, 16'h0, 16'h0, 16'hFFFF}, 4'b0000);
        wait_idle();

        // 5: back-pressure on neuron 0 for 10 cycles
        set_row(0, {4{16'h0800}}, 16'h0000);
        set_row(1, {4{16'h0800}}, 16'h0000);
        expect_out(16'h2000, 1'b0); expect_out(16'h2000, 1'b0);
        bus.DOUT_RDY = 1'b0;
        frame({4{16'h1000}}, 4'b0000);
        wait_sig(1'b1);
        repeat (10) @(negedge clk);
        bus.DOUT_RDY = 1'b1;
        wait_idle();

        // 6: reset mid-MAC clears outputs asynchronously, then a clean frame
        frame({4{16'h1000}}, 4'b0000);
        wait_sig(1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", {7'd0, bus.DIN_RDY, bus.W_RD, bus.DOUT_VLD, bus.DOUT_OVFL,
                                       bus.BUSY, bus.DOUT, bus.W_ADDR}, 32'd0);
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_out(16'h2000, 1'b0); expect_out(16'h2000, 1'b0);
        frame({4{16'h1000}}, 4'b0000);
        wait_idle();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
